// File: rtl/sd_spi_card_mux.sv
// SPI bus multiplexer that routes one SPI host to one of several SD card slots.
// Slot changes are deferred until the bus has been idle long enough to be safe.
module sd_spi_card_mux #(
    parameter int NUM_CARDS  = 2,
    parameter int IDLE_GUARD = 16,
    parameter int LED_BITS   = 22,
    localparam int SELW      = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 host_cs_n,
    input  logic                 host_clk,
    input  logic                 host_mosi,
    output logic                 host_miso,
    output logic [NUM_CARDS-1:0] card_cs_n,
    output logic [NUM_CARDS-1:0] card_clk,
    output logic [NUM_CARDS-1:0] card_mosi,
    input  logic [NUM_CARDS-1:0] card_miso,
    input  logic                 sel_wr,
    input  logic [SELW-1:0]      sel_data,
    output logic [SELW-1:0]      active_sel,
    output logic                 switch_pending,
    output logic                 sel_err,
    output logic                 testled
);

    typedef enum logic [1:0] {
        BUSY,
        GUARD,
        READY
    } bus_state_t;

    localparam logic [7:0] GUARD_LAST = 8'(IDLE_GUARD - 1);

    bus_state_t          state;
    logic [7:0]          guard_cnt;
    logic [SELW-1:0]     pending;
    logic [LED_BITS-1:0] led_cnt;
    logic                sel_valid;
    logic                any_low;

    assign sel_valid = 32'(sel_data) < NUM_CARDS;

    // Idle slots are parked with cs_n high, clock low and mosi high.
    always_comb begin
        card_cs_n = '1;
        card_clk  = '0;
        card_mosi = '1;
        host_miso = 1'b1;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (active_sel == SELW'(i)) begin
                card_cs_n[i] = host_cs_n;
                card_clk[i]  = host_clk;
                card_mosi[i] = host_mosi;
                host_miso    = card_miso[i];
            end
        end
    end

    assign any_low = ~&card_cs_n;
    assign testled = any_low | (|led_cnt);

    // The first high cycle out of BUSY already counts toward the guard interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= GUARD;
            guard_cnt      <= 8'd0;
            active_sel     <= '0;
            pending        <= '0;
            switch_pending <= 1'b0;
            sel_err        <= 1'b0;
        end else begin
            if (!host_cs_n) begin
                state     <= BUSY;
                guard_cnt <= 8'd0;
            end else begin
                case (state)
                    BUSY: begin
                        state     <= GUARD;
                        guard_cnt <= 8'd1;
                    end
                    GUARD: begin
                        if (guard_cnt >= GUARD_LAST) begin
                            state <= READY;
                        end else if (guard_cnt != 8'hFF) begin
                            guard_cnt <= guard_cnt + 8'd1;
                        end
                    end
                    READY: begin
                        if (switch_pending) begin
                            active_sel     <= pending;
                            switch_pending <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= GUARD;
                        guard_cnt <= 8'd0;
                    end
                endcase
            end

            // A write landing on the apply edge re-arms the request.
            if (sel_wr) begin
                if (sel_valid) begin
                    pending        <= sel_data;
                    switch_pending <= 1'b1;
                    sel_err        <= 1'b0;
                end else begin
                    sel_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_cnt <= '0;
        end else if (any_low) begin
            led_cnt <= '1;
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - LED_BITS'(1);
        end
    end

endmodule

// File: tb/tb_sd_spi_card_mux.sv
// Bench for sd_spi_card_mux: directed scenarios followed by random traffic,
// checked against a cycle-level model built from idle-run counting.
module tb_sd_spi_card_mux;

    localparam int NC = 3;
    localparam int IG = 16;
    localparam int LB = 4;
    localparam int SW = 2;
    localparam int LED_MAX = (1 << LB) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_cs_n;
    logic          host_clk;
    logic          host_mosi;
    logic          host_miso;
    logic [NC-1:0] card_cs_n;
    logic [NC-1:0] card_clk;
    logic [NC-1:0] card_mosi;
    logic [NC-1:0] card_miso;
    logic          sel_wr;
    logic [SW-1:0] sel_data;
    logic [SW-1:0] active_sel;
    logic          switch_pending;
    logic          sel_err;
    logic          testled;

    int checks   = 0;
    int failures = 0;

    int m_active;
    int m_pend;
    bit m_sp;
    bit m_err;
    int high_run;
    int m_led;

    sd_spi_card_mux #(
        .NUM_CARDS (NC),
        .IDLE_GUARD(IG),
        .LED_BITS  (LB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .host_cs_n     (host_cs_n),
        .host_clk      (host_clk),
        .host_mosi     (host_mosi),
        .host_miso     (host_miso),
        .card_cs_n     (card_cs_n),
        .card_clk      (card_clk),
        .card_mosi     (card_mosi),
        .card_miso     (card_miso),
        .sel_wr        (sel_wr),
        .sel_data      (sel_data),
        .active_sel    (active_sel),
        .switch_pending(switch_pending),
        .sel_err       (sel_err),
        .testled       (testled)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_pend   = 0;
        m_sp     = 1'b0;
        m_err    = 1'b0;
        high_run = 0;
        m_led    = 0;
    endtask

    // The bus counts as settled once IG high cycles have elapsed in a row.
    task automatic model_edge();
        bit ready;
        if (rst) begin
            model_reset();
        end else begin
            ready = (high_run >= IG);
            if (ready && m_sp && host_cs_n) begin
                m_active = m_pend;
                m_sp     = 1'b0;
            end
            if (sel_wr) begin
                if (int'(sel_data) < NC) begin
                    m_pend = int'(sel_data);
                    m_sp   = 1'b1;
                    m_err  = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            high_run = host_cs_n ? ((high_run < 1000) ? high_run + 1 : high_run) : 0;
            m_led    = !host_cs_n ? LED_MAX : ((m_led > 0) ? m_led - 1 : 0);
        end
    endtask

    task automatic check_output();
        logic [NC-1:0] e_cs;
        logic [NC-1:0] e_clk;
        logic [NC-1:0] e_mosi;
        for (int i = 0; i < NC; i++) begin
            e_cs[i]   = (i == m_active) ? host_cs_n : 1'b1;
            e_clk[i]  = (i == m_active) ? host_clk  : 1'b0;
            e_mosi[i] = (i == m_active) ? host_mosi : 1'b1;
        end
        chk("active_sel", 32'(active_sel), 32'(m_active));
        chk("switch_pending", 32'(switch_pending), 32'(m_sp));
        chk("sel_err", 32'(sel_err), 32'(m_err));
        chk("testled", 32'(testled), 32'((!host_cs_n) || (m_led != 0)));
        chk("card_cs_n", 32'(card_cs_n), 32'(e_cs));
        chk("card_clk", 32'(card_clk), 32'(e_clk));
        chk("card_mosi", 32'(card_mosi), 32'(e_mosi));
        chk("host_miso", 32'(host_miso), 32'(card_miso[m_active]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_output();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int led_on;
        int run_left;

        rst       = 1'b1;
        host_cs_n = 1'b1;
        host_clk  = 1'b0;
        host_mosi = 1'b1;
        card_miso = 3'b101;
        sel_wr    = 1'b0;
        sel_data  = '0;
        model_reset();
        @(negedge clk);
        check_output();
        ticks(2);
        chk("reset_active", 32'(active_sel), 32'd0);
        rst = 1'b0;

        // Idle bus: a valid write switches on the following edge.
        ticks(20);
        sel_wr   = 1'b1;
        sel_data = 2'd1;
        tick();
        chk("pulse_sp_high", 32'(switch_pending), 32'd1);
        sel_wr = 1'b0;
        tick();
        chk("switch_done", 32'(active_sel), 32'd1);
        chk("pulse_sp_low", 32'(switch_pending), 32'd0);

        // MISO routing and parked idle slots while the clock toggles.
        card_miso = 3'b101;
        host_cs_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            host_clk  = ~host_clk;
            host_mosi = 1'(i);
            #1 check_output();
        end
        chk("miso_slot1", 32'(host_miso), 32'd0);

        // Request during a transfer waits for IG idle cycles.
        sel_wr   = 1'b1;
        sel_data = 2'd2;
        tick();
        sel_wr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            host_clk = ~host_clk;
            tick();
        end
        host_clk  = 1'b0;
        host_cs_n = 1'b1;
        ticks(15);
        chk("guard_edge15", 32'(active_sel), 32'd1);
        tick();
        chk("guard_edge16", 32'(active_sel), 32'd1);
        tick();
        chk("guard_edge17", 32'(active_sel), 32'd2);

        // Out-of-range write flags an error; a valid one clears it.
        sel_wr   = 1'b1;
        sel_data = 2'd3;
        tick();
        chk("bad_sel_err", 32'(sel_err), 32'd1);
        chk("bad_sel_keep", 32'(active_sel), 32'd2);
        sel_data = 2'd0;
        tick();
        chk("good_sel_err", 32'(sel_err), 32'd0);
        sel_wr = 1'b0;
        tick();
        chk("good_sel_apply", 32'(active_sel), 32'd0);

        // Rewriting the already active slot still retires the request.
        sel_wr   = 1'b1;
        sel_data = 2'd0;
        tick();
        sel_wr = 1'b0;
        tick();
        chk("same_sel_sp", 32'(switch_pending), 32'd0);

        // A one-cycle low at guard count 10 restarts the guard interval.
        host_cs_n = 1'b0;
        sel_wr    = 1'b1;
        sel_data  = 2'd1;
        tick();
        sel_wr = 1'b0;
        ticks(3);
        host_cs_n = 1'b1;
        ticks(10);
        host_cs_n = 1'b0;
        tick();
        host_cs_n = 1'b1;
        ticks(16);
        chk("glitch_hold", 32'(active_sel), 32'd0);
        tick();
        chk("glitch_apply", 32'(active_sel), 32'd1);

        // Write landing on the apply edge becomes the next pending request.
        sel_wr   = 1'b1;
        sel_data = 2'd2;
        tick();
        sel_data = 2'd0;
        tick();
        chk("overlap_active", 32'(active_sel), 32'd2);
        chk("overlap_sp", 32'(switch_pending), 32'd1);
        sel_wr = 1'b0;
        tick();
        chk("overlap_next", 32'(active_sel), 32'd0);

        // Latest valid write wins; the trailing invalid one only sets the error.
        host_cs_n = 1'b0;
        sel_wr    = 1'b1;
        sel_data  = 2'd1;
        tick();
        sel_data = 2'd2;
        tick();
        sel_data = 2'd3;
        tick();
        sel_wr    = 1'b0;
        host_cs_n = 1'b1;
        ticks(17);
        chk("latest_wins", 32'(active_sel), 32'd2);
        chk("latest_err", 32'(sel_err), 32'd1);

        // Activity LED stretch after a short chip-select burst.
        ticks(20);
        host_cs_n = 1'b0;
        ticks(3);
        chk("led_during", 32'(testled), 32'd1);
        host_cs_n = 1'b1;
        #1;
        led_on = 0;
        for (int i = 0; i < 20; i++) begin
            if (testled) led_on++;
            tick();
        end
        chk("led_stretch", 32'(led_on), 32'd15);

        // Asynchronous reset mid-transfer snaps routing back to slot 0.
        host_cs_n = 1'b0;
        #1 rst = 1'b1;
        #1 model_reset();
        chk("rst_async_sel", 32'(active_sel), 32'd0);
        chk("rst_async_cs", 32'(card_cs_n), 32'b110);
        check_output();
        ticks(2);
        rst       = 1'b0;
        host_cs_n = 1'b1;
        sel_wr    = 1'b1;
        sel_data  = 2'd1;
        tick();
        sel_wr = 1'b0;
        ticks(14);
        chk("post_rst_hold", 32'(active_sel), 32'd0);
        ticks(2);
        chk("post_rst_apply", 32'(active_sel), 32'd1);

        // Random traffic with bursty chip-select runs.
        run_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (run_left == 0) begin
                host_cs_n = ~host_cs_n;
                run_left  = host_cs_n ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 8));
            end
            run_left--;
            host_clk  = 1'($urandom);
            host_mosi = 1'($urandom);
            card_miso = 3'($urandom);
            sel_wr    = ($urandom_range(0, 5) == 0);
            sel_data  = 2'($urandom_range(0, 3));
            #1 check_output();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
